// File: rtl/regfile_stack.sv
// regfile_stack: register file with a program counter, a link register and a
// hardware LIFO. The LIFO holds both data words and return addresses.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   addr              register address for read, write, push and pop
//   wr_en, csrc       register write enable and write-source select
//                     (0 data_in, 1 literal, 2 ambain, 3 datacee)
//   data_in, literal, ambain, datacee
//                     write sources; the low PC_W bits of literal are also
//                     the call/jump target
//   cpc, ceenz        PC control (0 hold, 1 inc, 2 skip-if-clear, 3 jump)
//                     and the skip condition
//   call, ret, push, pop, eint
//                     control strobes
//   data_out          combinational read of word[addr]
//   regs              words 0..7 flattened, word 0 in the LSBs
//   pc, lnk, sp       program counter, link register, stack occupancy
//   stk_full, stk_empty
//                     combinational occupancy flags
//   stk_err           sticky stack fault flag (cleared only by reset)
//   in_isr            interrupt service active
module regfile_stack #(
    parameter int unsigned     DATA_W    = 8,
    parameter int unsigned     ADDR_W    = 5,
    parameter int unsigned     PC_W      = 8,
    parameter int unsigned     STK_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(0),
    parameter logic [PC_W-1:0] INT_VEC   = PC_W'(249)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                addr,
    input  logic                             wr_en,
    input  logic [1:0]                       csrc,
    input  logic [DATA_W-1:0]                data_in,
    input  logic [DATA_W-1:0]                literal,
    input  logic [DATA_W-1:0]                ambain,
    input  logic [DATA_W-1:0]                datacee,
    input  logic [1:0]                       cpc,
    input  logic                             ceenz,
    input  logic                             call,
    input  logic                             ret,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             eint,
    output logic [DATA_W-1:0]                data_out,
    output logic [8*DATA_W-1:0]              regs,
    output logic [PC_W-1:0]                  pc,
    output logic [PC_W-1:0]                  lnk,
    output logic [$clog2(STK_DEPTH+1)-1:0]   sp,
    output logic                             stk_full,
    output logic                             stk_empty,
    output logic                             stk_err,
    output logic                             in_isr
);

    localparam int unsigned NWORDS = 1 << ADDR_W;
    localparam int unsigned SP_W   = $clog2(STK_DEPTH + 1);
    localparam int unsigned IDX_W  = $clog2(STK_DEPTH);
    localparam int unsigned STK_W  = (DATA_W > PC_W) ? DATA_W : PC_W;

    logic [DATA_W-1:0] rf  [NWORDS];
    logic [STK_W-1:0]  stk [STK_DEPTH];

    logic [DATA_W-1:0] wr_data;
    logic              eint_req;
    logic [2:0]        n_ops;
    logic              single;
    logic              do_eint;
    logic              do_call;
    logic              do_ret;
    logic              do_push;
    logic              do_pop;
    logic              fault;
    logic [STK_W-1:0]  top_val;
    logic [STK_W-1:0]  below_val;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_seq;
    logic [PC_W-1:0]   pc_nxt;
    logic [PC_W-1:0]   lnk_nxt;
    logic              isr_nxt;
    logic              stk_wr;
    logic              stk_rd;
    logic [STK_W-1:0]  stk_wr_val;

    // Occupancy flags and read ports
    assign stk_empty = (sp == SP_W'(0));
    assign stk_full  = (sp == SP_W'(STK_DEPTH));
    assign data_out  = rf[addr];

    for (genvar g = 0; g < 8; g++) begin : g_regs
        if (g < NWORDS) begin : g_word
            assign regs[g*DATA_W +: DATA_W] = rf[g];
        end else begin : g_zero
            assign regs[g*DATA_W +: DATA_W] = '0;
        end
    end

    // Top and second-from-top entries; zero when not present
    always_comb begin
        top_val   = '0;
        below_val = '0;
        if (!stk_empty) begin
            top_val = stk[IDX_W'(sp - SP_W'(1))];
        end
        if (sp >= SP_W'(2)) begin
            below_val = stk[IDX_W'(sp - SP_W'(2))];
        end
    end

    // Write-source mux
    always_comb begin
        wr_data = data_in;
        case (csrc)
            2'd0:    wr_data = data_in;
            2'd1:    wr_data = literal;
            2'd2:    wr_data = ambain;
            default: wr_data = datacee;
        endcase
    end

    // Sequential PC target used whenever no flow-control stack op succeeds
    always_comb begin
        pc_inc = pc + PC_W'(1);
        pc_seq = pc;
        case (cpc)
            2'd0:    pc_seq = pc;
            2'd1:    pc_seq = pc_inc;
            2'd2:    pc_seq = ceenz ? pc_inc : pc + PC_W'(2);
            default: pc_seq = PC_W'(literal);
        endcase
    end

    // Stack-op arbitration: two or more requested ops perform none of them;
    // a lone op that would overflow or underflow is dropped as a fault.
    always_comb begin
        eint_req = eint && !in_isr;
        n_ops    = 3'(eint_req) + 3'(call) + 3'(ret) + 3'(push) + 3'(pop);
        single   = (n_ops == 3'd1);

        do_eint  = single && eint_req && !stk_full;
        do_call  = single && call     && !stk_full;
        do_ret   = single && ret      && !stk_empty;
        do_push  = single && push     && !stk_full;
        do_pop   = single && pop      && !stk_empty;

        fault    = (n_ops > 3'd1) ||
                   (single && (eint_req || call || push) && stk_full) ||
                   (single && (ret || pop) && stk_empty);
    end

    // Next PC, link, ISR state and stack port
    always_comb begin
        pc_nxt     = pc_seq;
        lnk_nxt    = lnk;
        isr_nxt    = in_isr;
        stk_wr     = 1'b0;
        stk_rd     = 1'b0;
        stk_wr_val = '0;

        if (do_eint) begin
            pc_nxt     = INT_VEC;
            lnk_nxt    = pc;
            isr_nxt    = 1'b1;
            stk_wr     = 1'b1;
            stk_wr_val = STK_W'(pc);
        end else if (do_call) begin
            pc_nxt     = PC_W'(literal);
            lnk_nxt    = pc_inc;
            stk_wr     = 1'b1;
            stk_wr_val = STK_W'(pc_inc);
        end else if (do_ret) begin
            pc_nxt     = PC_W'(top_val);
            lnk_nxt    = PC_W'(below_val);
            isr_nxt    = 1'b0;
            stk_rd     = 1'b1;
        end else if (do_push) begin
            stk_wr     = 1'b1;
            stk_wr_val = STK_W'(rf[addr]);
        end else if (do_pop) begin
            stk_rd     = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NWORDS); i++) begin
                rf[ADDR_W'(i)] <= '0;
            end
            for (int i = 0; i < int'(STK_DEPTH); i++) begin
                stk[IDX_W'(i)] <= '0;
            end
            pc      <= RESET_PC;
            lnk     <= '0;
            sp      <= '0;
            stk_err <= 1'b0;
            in_isr  <= 1'b0;
        end else begin
            pc     <= pc_nxt;
            lnk    <= lnk_nxt;
            in_isr <= isr_nxt;
            if (fault) begin
                stk_err <= 1'b1;
            end
            if (stk_wr) begin
                stk[IDX_W'(sp)] <= stk_wr_val;
                sp              <= sp + SP_W'(1);
            end else if (stk_rd) begin
                sp <= sp - SP_W'(1);
            end
            // A successful pop takes the write port from wr_en
            if (do_pop) begin
                rf[addr] <= DATA_W'(top_val);
            end else if (wr_en) begin
                rf[addr] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_stack.sv
// Self-checking bench for regfile_stack: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based behavioural model.
module tb_regfile_stack;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 5;
    localparam int PC_W      = 8;
    localparam int STK_DEPTH = 8;
    localparam int SP_W      = $clog2(STK_DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic [1:0]        csrc;
    logic [DATA_W-1:0] data_in, literal, ambain, datacee;
    logic [1:0]        cpc;
    logic              ceenz, call, ret, push, pop, eint;
    logic [DATA_W-1:0] data_out;
    logic [8*DATA_W-1:0] regs;
    logic [PC_W-1:0]   pc, lnk;
    logic [SP_W-1:0]   sp;
    logic              stk_full, stk_empty, stk_err, in_isr;

    always #5 clk = ~clk;

    regfile_stack #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .STK_DEPTH(STK_DEPTH),
        .RESET_PC(8'd0), .INT_VEC(8'd249)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .csrc(csrc),
        .data_in(data_in), .literal(literal), .ambain(ambain), .datacee(datacee),
        .cpc(cpc), .ceenz(ceenz), .call(call), .ret(ret), .push(push), .pop(pop),
        .eint(eint), .data_out(data_out), .regs(regs), .pc(pc), .lnk(lnk), .sp(sp),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err), .in_isr(in_isr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [7:0] m_rf [32];
    logic [7:0] m_stk [$];
    logic [7:0] m_pc, m_lnk;
    bit         m_isr, m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 8'd0;
        m_stk.delete();
        m_pc  = 8'd0;
        m_lnk = 8'd0;
        m_isr = 1'b0;
        m_err = 1'b0;
    endtask

    // Apply one clock edge worth of the rules to the model
    task automatic model_step();
        logic [7:0] src, pc_seq, pre;
        bit er, full, empty;
        int nops;
        if (rst) begin
            model_reset();
            return;
        end
        case (csrc)
            2'd0: src = data_in;
            2'd1: src = literal;
            2'd2: src = ambain;
            default: src = datacee;
        endcase
        case (cpc)
            2'd0: pc_seq = m_pc;
            2'd1: pc_seq = m_pc + 8'd1;
            2'd2: pc_seq = ceenz ? m_pc + 8'd1 : m_pc + 8'd2;
            default: pc_seq = literal;
        endcase
        pre   = m_rf[addr];
        full  = (m_stk.size() == STK_DEPTH);
        empty = (m_stk.size() == 0);
        if (wr_en) m_rf[addr] = src;
        er   = eint && !m_isr;
        nops = int'(er) + int'(call) + int'(ret) + int'(push) + int'(pop);
        if (nops > 1) begin
            m_err = 1'b1;
            m_pc  = pc_seq;
        end else if (er) begin
            if (full) begin m_err = 1'b1; m_pc = pc_seq; end
            else begin
                m_stk.push_back(m_pc);
                m_lnk = m_pc;
                m_pc  = 8'd249;
                m_isr = 1'b1;
            end
        end else if (call) begin
            if (full) begin m_err = 1'b1; m_pc = pc_seq; end
            else begin
                m_stk.push_back(m_pc + 8'd1);
                m_lnk = m_pc + 8'd1;
                m_pc  = literal;
            end
        end else if (ret) begin
            if (empty) begin m_err = 1'b1; m_pc = pc_seq; end
            else begin
                m_pc  = m_stk.pop_back();
                m_lnk = (m_stk.size() > 0) ? m_stk[$] : 8'd0;
                m_isr = 1'b0;
            end
        end else if (push) begin
            if (full) m_err = 1'b1;
            else m_stk.push_back(pre);
            m_pc = pc_seq;
        end else if (pop) begin
            if (empty) m_err = 1'b1;
            else m_rf[addr] = m_stk.pop_back();
            m_pc = pc_seq;
        end else begin
            m_pc = pc_seq;
        end
    endtask

    task automatic compare_all();
        logic [63:0] exp_regs;
        for (int i = 0; i < 8; i++) exp_regs[i*8 +: 8] = m_rf[i];
        chk("pc",        64'(pc),        64'(m_pc));
        chk("lnk",       64'(lnk),       64'(m_lnk));
        chk("sp",        64'(sp),        64'(m_stk.size()));
        chk("stk_full",  64'(stk_full),  64'(m_stk.size() == STK_DEPTH));
        chk("stk_empty", 64'(stk_empty), 64'(m_stk.size() == 0));
        chk("stk_err",   64'(stk_err),   64'(m_err));
        chk("in_isr",    64'(in_isr),    64'(m_isr));
        chk("data_out",  64'(data_out),  64'(m_rf[addr]));
        chk("regs",      regs,           exp_regs);
    endtask

    task automatic idle();
        rst = 1'b0; addr = '0; wr_en = 1'b0; csrc = 2'd0;
        data_in = '0; literal = '0; ambain = '0; datacee = '0;
        cpc = 2'd0; ceenz = 1'b0;
        call = 1'b0; ret = 1'b0; push = 1'b0; pop = 1'b0; eint = 1'b0;
    endtask

    // One clock: model update, edge, then compare away from the edge
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic jump(input logic [7:0] target);
        idle(); cpc = 2'd3; literal = target; cyc();
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1'b1;
        cyc();
        chk("rst_pc", 64'(pc), 64'h0);
        chk("rst_sp", 64'(sp), 64'h0);
        chk("rst_err", 64'(stk_err), 64'h0);

        // Literal write to word 3
        idle(); wr_en = 1'b1; csrc = 2'd1; literal = 8'h5A; addr = 5'd3; cyc();
        chk("wr_data_out", 64'(data_out), 64'h5A);
        chk("wr_regs3", 64'(regs[31:24]), 64'h5A);

        // Conditional skip and wrap
        jump(8'd10);
        idle(); cpc = 2'd2; ceenz = 1'b1; cyc();
        chk("skip_c1", 64'(pc), 64'd11);
        jump(8'd10);
        idle(); cpc = 2'd2; ceenz = 1'b0; cyc();
        chk("skip_c0", 64'(pc), 64'd12);
        jump(8'd255);
        idle(); cpc = 2'd1; cyc();
        chk("pc_wrap", 64'(pc), 64'd0);

        // Call / return
        jump(8'd20);
        idle(); call = 1'b1; literal = 8'd40; cyc();
        chk("call_pc", 64'(pc), 64'd40);
        chk("call_lnk", 64'(lnk), 64'd21);
        chk("call_sp", 64'(sp), 64'd1);
        idle(); ret = 1'b1; cyc();
        chk("ret_pc", 64'(pc), 64'd21);
        chk("ret_sp", 64'(sp), 64'd0);
        chk("ret_lnk", 64'(lnk), 64'd0);

        // Interrupt entry, nested request ignored, return
        jump(8'd7);
        idle(); eint = 1'b1; cyc();
        chk("int_pc", 64'(pc), 64'd249);
        chk("int_isr", 64'(in_isr), 64'd1);
        chk("int_sp", 64'(sp), 64'd1);
        idle(); eint = 1'b1; cyc();
        chk("int2_pc", 64'(pc), 64'd249);
        chk("int2_sp", 64'(sp), 64'd1);
        idle(); ret = 1'b1; cyc();
        chk("reti_pc", 64'(pc), 64'd7);
        chk("reti_isr", 64'(in_isr), 64'd0);

        // Fill, overflow, drain, underflow
        for (int i = 0; i < STK_DEPTH; i++) begin
            idle(); push = 1'b1; addr = 5'd3; cyc();
        end
        chk("fill_full", 64'(stk_full), 64'd1);
        chk("fill_err", 64'(stk_err), 64'd0);
        idle(); wr_en = 1'b1; csrc = 2'd0; data_in = 8'h77; addr = 5'd4; cyc();
        idle(); push = 1'b1; addr = 5'd4; cyc();
        chk("ovf_sp", 64'(sp), 64'd8);
        chk("ovf_err", 64'(stk_err), 64'd1);
        idle(); pop = 1'b1; addr = 5'd5; cyc();
        chk("ovf_top", 64'(data_out), 64'h5A);
        for (int i = 0; i < STK_DEPTH - 1; i++) begin
            idle(); pop = 1'b1; addr = 5'd5; cyc();
        end
        chk("drain_empty", 64'(stk_empty), 64'd1);
        idle(); pop = 1'b1; addr = 5'd5; cyc();
        chk("unf_word", 64'(data_out), 64'h5A);
        chk("unf_err", 64'(stk_err), 64'd1);

        // Push and pop together
        idle(); rst = 1'b1; cyc();
        idle(); push = 1'b1; addr = 5'd3; cyc();
        idle(); push = 1'b1; pop = 1'b1; cpc = 2'd1; addr = 5'd3; cyc();
        chk("conf_sp", 64'(sp), 64'd1);
        chk("conf_err", 64'(stk_err), 64'd1);
        chk("conf_pc", 64'(pc), 64'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst     = ($urandom_range(0, 199) == 0);
            addr    = 5'($urandom_range(0, 31));
            wr_en   = 1'($urandom_range(0, 1));
            csrc    = 2'($urandom_range(0, 3));
            data_in = 8'($urandom);
            literal = 8'($urandom);
            ambain  = 8'($urandom);
            datacee = 8'($urandom);
            cpc     = 2'($urandom_range(0, 3));
            ceenz   = 1'($urandom_range(0, 1));
            eint    = ($urandom_range(0, 11) == 0);
            call    = ($urandom_range(0, 7) == 0);
            ret     = ($urandom_range(0, 6) == 0);
            push    = ($urandom_range(0, 3) == 0);
            pop     = ($urandom_range(0, 4) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
